// File: rtl/histo_lut_builder.sv
// histo_lut_builder: walks the CDF RAM once per frame and writes the
// histogram-equalisation LUT.
//     lut[v] = ((cdf[v] - cdf_min) * (2^PixelSize - 1)) / (TotalPixels - cdf_min)
// A single restoring divider is shared by all entries. It produces one quotient
// bit per cycle.
// Build option: define HISTO_LUT_ROUND_EN for round-half-up division. Left
// undefined, the division truncates.
//
// state | meaning
// IDLE  | waiting for start; cdf_min latched on an accepted start
// RD    | drive CDF read address = v
// WT    | capture CDF read data
// PREP  | form numerator and denominator, or load the identity value when den == 0
// DIV   | restoring divide, one quotient bit per cycle
// WR    | LUT write strobe for level v
// FIN   | one-cycle done pulse, then back to IDLE
module histo_lut_builder #(
    parameter int PixelSize   = 8,
    parameter int TotalPixels = 640*480,
    parameter int histoWidth  = $clog2(TotalPixels)
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  start_i,
    input  logic [histoWidth-1:0] cdf_min_i,
    output logic [PixelSize-1:0]  cdf_rd_addr_o,
    input  logic [histoWidth-1:0] cdf_rd_data_i,
    output logic                  lut_wr_en_o,
    output logic [PixelSize-1:0]  lut_wr_addr_o,
    output logic [PixelSize-1:0]  lut_wr_data_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int HW   = histoWidth;
    localparam int PW   = PixelSize;
    localparam int NUMW = HW + PW;
`ifdef HISTO_LUT_ROUND_EN
    localparam int RND  = 1;
`else
    localparam int RND  = 0;
`endif
    localparam int NUMR = NUMW + RND;
    localparam int CW   = $clog2(NUMR + 1);
    localparam logic [HW-1:0] TOTAL_W = HW'(TotalPixels);
    localparam logic [PW-1:0] MAXV    = {PW{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WT, S_PREP, S_DIV, S_WR, S_FIN
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   v_q, v_d;
    logic [HW-1:0]   cdf_min_q, cdf_min_d;
    logic [HW-1:0]   cdf_q, cdf_d;
    logic [HW-1:0]   den_q, den_d;
    logic [HW-1:0]   rem_q, rem_d;
    logic [NUMR-1:0] num_q, num_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [HW-1:0]   diff_w;
    logic [HW-1:0]   den_w;
    logic [NUMW-1:0] diff_ext_w;
    logic [NUMW-1:0] prod_w;
    logic [HW:0]     trial_w;
    logic [HW:0]     sub_w;
    logic            ge_w;

    // Operand preparation and one restoring-divide step
    always_comb begin
        diff_w     = (cdf_q >= cdf_min_q) ? (cdf_q - cdf_min_q) : '0;
        den_w      = (cdf_min_q > TOTAL_W) ? '0 : (TOTAL_W - cdf_min_q);
        diff_ext_w = {{PW{1'b0}}, diff_w};
        prod_w     = (diff_ext_w << PW) - diff_ext_w;
        trial_w    = {rem_q, num_q[NUMR-1]};
        sub_w      = trial_w - {1'b0, den_q};
        ge_w       = (trial_w >= {1'b0, den_q});
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        v_d       = v_q;
        cdf_min_d = cdf_min_q;
        cdf_d     = cdf_q;
        den_d     = den_q;
        rem_d     = rem_q;
        num_d     = num_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    cdf_min_d = cdf_min_i;
                    v_d       = '0;
                    state_d   = S_RD;
                end
            end
            S_RD: state_d = S_WT;
            S_WT: begin
                cdf_d   = cdf_rd_data_i;
                state_d = S_PREP;
            end
            S_PREP: begin
                den_d = den_w;
                rem_d = '0;
                cnt_d = CW'(NUMR - 1);
                if (den_w == '0) begin
                    // Single-level frame: identity map, divider bypassed
                    num_d   = NUMR'(v_q);
                    state_d = S_WR;
                end else begin
`ifdef HISTO_LUT_ROUND_EN
                    num_d = NUMR'(prod_w) + NUMR'(den_w >> 1);
`else
                    num_d = prod_w;
`endif
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                // Quotient bits shift into num_q from the bottom as the numerator leaves the top
                rem_d = ge_w ? sub_w[HW-1:0] : trial_w[HW-1:0];
                num_d = {num_q[NUMR-2:0], ge_w};
                if (cnt_q == '0) state_d = S_WR;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_WR: begin
                if (v_q == MAXV) begin
                    state_d = S_FIN;
                end else begin
                    v_d     = v_q + 1'b1;
                    state_d = S_RD;
                end
            end
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= S_IDLE;
            v_q       <= '0;
            cdf_min_q <= '0;
            cdf_q     <= '0;
            den_q     <= '0;
            rem_q     <= '0;
            num_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            v_q       <= v_d;
            cdf_min_q <= cdf_min_d;
            cdf_q     <= cdf_d;
            den_q     <= den_d;
            rem_q     <= rem_d;
            num_q     <= num_d;
            cnt_q     <= cnt_d;
        end
    end

    // Outputs decoded from state; an oversized quotient saturates to full scale
    always_comb begin
        cdf_rd_addr_o = v_q;
        lut_wr_addr_o = v_q;
        lut_wr_data_o = (|num_q[NUMR-1:PW]) ? MAXV : num_q[PW-1:0];
        lut_wr_en_o   = (state_q == S_WR);
        done_o        = (state_q == S_FIN);
        busy_o        = (state_q != S_IDLE) && (state_q != S_FIN);
    end

endmodule
